// File: rtl/debug_trace_pkg.sv
// Shared types for the commit-stage trace buffer: FSM states, the stored entry
// layout and the drop-counter width.
package debug_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DRAIN = 2'd3
    } trace_state_t;

    // 163-bit entry: pc, instr, capture timestamp and three event flags
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] cycle;
        logic        cache_miss;
        logic        branch_taken;
        logic        stall;
    } trace_entry_t;

    localparam int DROP_W = 16;

endpackage

// File: rtl/debug_trace_ram.sv
// Trace entry storage: one synchronous write port, one asynchronous read port
// so the drain port always shows the entry at the read pointer.
module debug_trace_ram
    import debug_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  trace_entry_t  wr_data,
    input  logic [AW-1:0] rd_addr,
    output trace_entry_t  rd_data
);

    trace_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/debug_trace_buffer.sv
// Circular trace buffer with arm/trigger/post-window capture and an oldest-first
// valid/ready drain. Option: DEBUG_TRACE_STALL_FILTER_EN ignores stall events.
module debug_trace_buffer
    import debug_trace_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int POST_CNT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [63:0]                in_pc,
    input  logic [31:0]                in_instr,
    input  logic                       in_cache_miss,
    input  logic                       in_branch_taken,
    input  logic                       in_stall,
    input  logic                       arm,
    input  logic                       trig,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [63:0]                out_pc,
    output logic [31:0]                out_instr,
    output logic [63:0]                out_cycle,
    output logic                       out_cache_miss,
    output logic                       out_branch_taken,
    output logic                       out_stall,
    output logic [63:0]                cycle_o,
    output logic [1:0]                 state_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [DROP_W-1:0]          drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    trace_state_t      state_reg, state_next;
    logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]     count_reg, post_left_reg;
    logic [63:0]       cycle_reg;
    logic [DROP_W-1:0] drop_reg;
    logic              filtered, capture, drop_evt, pop;
    trace_entry_t      wr_entry, rd_entry;

`ifdef DEBUG_TRACE_STALL_FILTER_EN
    assign filtered = in_stall;
`else
    assign filtered = 1'b0;
`endif

    assign capture  = in_valid && !filtered && (state_reg == ST_ARMED || state_reg == ST_POST);
    assign drop_evt = in_valid && !filtered && (state_reg == ST_DRAIN);
    assign pop      = out_valid && out_ready;

    assign wr_entry = '{pc: in_pc, instr: in_instr, cycle: cycle_reg,
                        cache_miss: in_cache_miss, branch_taken: in_branch_taken,
                        stall: in_stall};

    debug_trace_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .wr_en   (capture),
        .wr_addr (wr_ptr_reg),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_reg),
        .rd_data (rd_entry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (arm) state_next = ST_ARMED;
            ST_ARMED: begin
                if (trig) begin
                    if (POST_CNT == 0) state_next = ST_DRAIN;
                    else               state_next = ST_POST;
                end
            end
            ST_POST:  if (capture && post_left_reg == CW'(1)) state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (count_reg == '0 || (pop && count_reg == CW'(1))) state_next = ST_IDLE;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_reg == ST_DRAIN) && (count_reg != '0);
        state_o   = state_reg;
    end

    // A capture into a full buffer overwrites the oldest entry by dragging rd_ptr along.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            post_left_reg <= '0;
            drop_reg      <= '0;
            cycle_reg     <= '0;
        end else begin
            cycle_reg <= cycle_reg + 64'd1;
            if (state_reg == ST_IDLE && arm) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
                drop_reg   <= '0;
            end
            if (capture) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
                if (count_reg == CW'(DEPTH)) begin
                    rd_ptr_reg <= rd_ptr_reg + PW'(1);
                end else begin
                    count_reg <= count_reg + CW'(1);
                end
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
                count_reg  <= count_reg - CW'(1);
            end
            if (state_reg == ST_ARMED && trig) begin
                post_left_reg <= CW'(POST_CNT);
            end else if (state_reg == ST_POST && capture) begin
                post_left_reg <= post_left_reg - CW'(1);
            end
            if (drop_evt && drop_reg != '1) begin
                drop_reg <= drop_reg + DROP_W'(1);
            end
        end
    end

    assign out_pc           = rd_entry.pc;
    assign out_instr        = rd_entry.instr;
    assign out_cycle        = rd_entry.cycle;
    assign out_cache_miss   = rd_entry.cache_miss;
    assign out_branch_taken = rd_entry.branch_taken;
    assign out_stall        = rd_entry.stall;
    assign cycle_o          = cycle_reg;
    assign count_o          = count_reg;
    assign drop_cnt         = drop_reg;

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Directed bench for debug_trace_buffer (DEPTH=4, POST_CNT=2); honours
// DEBUG_TRACE_STALL_FILTER_EN when computing the stall-event expectation.
module tb_debug_trace_buffer;

    localparam int DEPTH    = 4;
    localparam int POST_CNT = 2;
    localparam int CW       = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst, in_valid, in_cache_miss, in_branch_taken, in_stall;
    logic          arm, trig, out_ready;
    logic [63:0]   in_pc;
    logic [31:0]   in_instr;
    logic          out_valid, out_cache_miss, out_branch_taken, out_stall;
    logic [63:0]   out_pc, out_cycle, cycle_o;
    logic [31:0]   out_instr;
    logic [1:0]    state_o;
    logic [CW-1:0] count_o;
    logic [15:0]   drop_cnt;

    int            pass_cnt  = 0;
    int            total_cnt = 0;
    logic [63:0]   cyc       = '0;
    logic [63:0]   rec_cyc [6];
    int            exp_cnt;

    debug_trace_buffer #(.DEPTH(DEPTH), .POST_CNT(POST_CNT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .in_cache_miss(in_cache_miss), .in_branch_taken(in_branch_taken), .in_stall(in_stall),
        .arm(arm), .trig(trig), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_cycle(out_cycle),
        .out_cache_miss(out_cache_miss), .out_branch_taken(out_branch_taken),
        .out_stall(out_stall), .cycle_o(cycle_o), .state_o(state_o),
        .count_o(count_o), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one edge; the bench's own cycle model follows the counter's reset rule.
    task automatic tick();
        @(posedge clk);
        cyc = rst ? 64'd0 : cyc + 64'd1;
        #1;
    endtask

    task automatic drive_event(input logic [63:0] pc, input logic cm, input logic bt, input logic st);
        in_valid = 1'b1; in_pc = pc; in_instr = 32'hA000_0000 | pc[31:0];
        in_cache_miss = cm; in_branch_taken = bt; in_stall = st;
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; in_pc = '0; in_instr = '0; in_cache_miss = 0;
        in_branch_taken = 0; in_stall = 0; arm = 0; trig = 0; out_ready = 0;
        tick(); tick();
        chk("rst_state", state_o, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_count", count_o, 0);
        chk("rst_cycle", cycle_o, 0);
        rst = 1'b0;
        tick(); chk("cycle_1", cycle_o, 1);
        tick(); chk("cycle_2", cycle_o, cyc);

        trig = 1; tick(); trig = 0;
        chk("trig_in_idle", state_o, 0);
        arm = 1; tick(); arm = 0;
        chk("armed", state_o, 1);
        chk("armed_count", count_o, 0);

        // Six events, trigger with the 4th: buffer wraps and keeps the last four.
        for (int i = 0; i < 6; i++) begin
            drive_event(64'h10 + 64'(4*i), i[0], i[1], 1'b0);
            trig = (i == 3);
            rec_cyc[i] = cyc;
            tick();
            if (i == 3) begin
                chk("post_state", state_o, 2);
                chk("full_count", count_o, 4);
            end
        end
        in_valid = 0; trig = 0;
        chk("drain_state", state_o, 3);
        chk("drain_count", count_o, 4);
        chk("drain_valid", out_valid, 1);

        out_ready = 0;
        for (int k = 0; k < 5; k++) begin
            in_valid = (k < 3);
            tick();
            chk("bp_pc", out_pc, 64'h18);
            chk("bp_valid", out_valid, 1);
        end
        in_valid = 0;
        chk("drop_3", drop_cnt, 3);

        out_ready = 1;
        for (int j = 0; j < 4; j++) begin
            chk("pop_valid", out_valid, 1);
            chk("pop_pc", out_pc, 64'h18 + 64'(4*j));
            chk("pop_instr", out_instr, 32'hA000_0018 + 32'(4*j));
            chk("pop_cycle", out_cycle, rec_cyc[j+2]);
            chk("pop_flags", {out_cache_miss, out_branch_taken, out_stall},
                {1'(j % 2), 1'((j + 2) / 2 % 2), 1'b0});
            $display("pop %0d pc=0x%0h cycle=%0d", j, out_pc, out_cycle);
            tick();
        end
        out_ready = 0;
        chk("idle_after_drain", state_o, 0);
        chk("idle_valid", out_valid, 0);
        chk("idle_count", count_o, 0);

        arm = 1; tick(); arm = 0;
        chk("rearm_drop_clr", drop_cnt, 0);
        drive_event(64'h40, 1'b0, 1'b0, 1'b1);
        tick();
`ifdef DEBUG_TRACE_STALL_FILTER_EN
        exp_cnt = 0;
`else
        exp_cnt = 1;
`endif
        chk("stall_count", count_o, exp_cnt);
        drive_event(64'h44, 1'b0, 1'b0, 1'b0); trig = 1; tick(); trig = 0;
        exp_cnt++;
        chk("post_again", state_o, 2);
        drive_event(64'h48, 1'b0, 1'b0, 1'b0); tick();
        drive_event(64'h4C, 1'b0, 1'b0, 1'b0); tick();
        exp_cnt += 2;
        chk("drain_again", state_o, 3);
        chk("drain_again_cnt", count_o, exp_cnt);

        drive_event(64'h50, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 65534; n++) tick();
        chk("drop_fffe", drop_cnt, 16'hFFFE);
        tick();
        chk("drop_ffff", drop_cnt, 16'hFFFF);
        for (int n = 0; n < 4465; n++) tick();
        chk("drop_sat", drop_cnt, 16'hFFFF);
        in_valid = 0;

        while (exp_cnt > 3) begin
            out_ready = 1; tick(); exp_cnt--;
        end
        out_ready = 0;
        chk("pre_rst_count", count_o, 3);
        chk("pre_rst_state", state_o, 3);
        rst = 1; tick(); rst = 0;
        chk("mid_rst_state", state_o, 0);
        chk("mid_rst_count", count_o, 0);
        chk("mid_rst_valid", out_valid, 0);

        arm = 1; trig = 1; tick(); arm = 0; trig = 0;
        chk("arm_trig_idle", state_o, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
